// File: rtl/frodo_mac_driver.sv
`default_nettype none
// ============================================================================
//  Module      : frodo_mac_driver
//  Description : Initiator for the Frodo 16-bit MAC (a*b + c). Accumulates
//                out = e + sum a_k*s_k (mod 2^16) by pulling (a,s) operand
//                pairs, issuing one MAC op per term and feeding each result
//                back as the next addend.
//  Revision    : 1.0 - initial release
// ============================================================================
module frodo_mac_driver #(
    parameter int LEN_W   = 11,
    parameter int TIMEOUT = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [15:0]       e_in,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [15:0]       op_a,
    input  logic [7:0]        op_s,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic              job_done,
    output logic              range_err,
    output logic              timeout_err,
    output logic              mac_en,
    output logic [15:0]       mac_a,
    output logic [7:0]        mac_b,
    output logic [15:0]       mac_c,
    input  logic              mac_done,
    input  logic [15:0]       mac_result
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [15:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             s_in_range;
    logic             last_term;
    logic             to_expire;

    // Secret must be a sign extension of bit 4 to be inside -16..15
    assign s_in_range = (op_s[7:4] == 4'h0) || (op_s[7:4] == 4'hF);
    assign last_term  = (cnt == LEN_W'(1));
    assign to_expire  = (to_cnt == TO_W'(TIMEOUT - 1));

    // The accumulator is the result; it is frozen while in OUT
    assign res_data = acc;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_OUT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (op_valid) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    state_nxt = last_term ? S_OUT : S_FETCH;
                end else if (to_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and MAC strobe outputs decoded from the state
    always_comb begin
        busy      = (state != S_IDLE);
        op_ready  = (state == S_FETCH);
        mac_en    = (state == S_ISSUE);
        res_valid = (state == S_OUT);
        job_done  = (state == S_OUT) && res_ready;
    end

    // Datapath: job setup, operand latch, accumulation, timeout and error flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc         <= '0;
            cnt         <= '0;
            to_cnt      <= '0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_c       <= '0;
            range_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc         <= e_in;
                        cnt         <= len;
                        range_err   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (op_valid) begin
                        mac_a <= op_a;
                        mac_b <= {{3{op_s[4]}}, op_s[4:0]};
                        mac_c <= acc;
                        if (!s_in_range) begin
                            range_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                end
                S_WAIT: begin
                    if (mac_done) begin
                        acc <= mac_result;
                        cnt <= cnt - LEN_W'(1);
                    end else if (to_expire) begin
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frodo_mac_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frodo_mac_driver
//  Description : Directed table-driven bench for frodo_mac_driver with a
//                2-cycle MAC responder model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frodo_mac_driver;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len = '0;
    logic [15:0] e_in = '0;
    logic        busy;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [7:0]  op_s = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        job_done;
    logic        range_err;
    logic        timeout_err;
    logic        mac_en;
    logic [15:0] mac_a;
    logic [7:0]  mac_b;
    logic [15:0] mac_c;
    logic        mac_done = 1'b0;
    logic [15:0] mac_result = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int en_cnt = 0;
    int hs_cnt = 0;
    bit mac_alive = 1'b1;

    frodo_mac_driver #(.LEN_W(11), .TIMEOUT(7)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .e_in(e_in),
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a),
        .op_s(op_s), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .job_done(job_done), .range_err(range_err),
        .timeout_err(timeout_err), .mac_en(mac_en), .mac_a(mac_a),
        .mac_b(mac_b), .mac_c(mac_c), .mac_done(mac_done),
        .mac_result(mac_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // MAC responder: samples operands one cycle after en, done two cycles after en
    logic        p1;
    logic [15:0] ca, cc;
    logic [7:0]  cb;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1       <= 1'b0;
            mac_done <= 1'b0;
        end else begin
            p1       <= mac_en;
            mac_done <= p1 & mac_alive;
            if (mac_en) begin
                ca <= mac_a;
                cb <= mac_b;
                cc <= mac_c;
            end
            if (p1) begin
                chk("mac_operands_held", {mac_a, mac_b, mac_c, 8'h0}, {ca, cb, cc, 8'h0});
                mac_result <= mac_c + mac_a * {{8{mac_b[7]}}, mac_b};
            end
        end
    end

    // Cycle, MAC-issue and operand-handshake counters
    always @(posedge clk) begin
        cyc++;
        if (rstn && mac_en) en_cnt++;
        if (rstn && op_valid && op_ready) hs_cnt++;
    end

    typedef struct {
        int          n;
        logic [15:0] e;
        logic [15:0] a[4];
        logic [7:0]  s[4];
        logic [15:0] exp;
        bit          rerr;
        int          gap;
        bit          poke;
    } vec_t;

    vec_t vecs[8];

    task automatic run_job(input vec_t v, input string tag);
        int en0, hs0, c0, w;
        en0 = en_cnt;
        hs0 = hs_cnt;
        @(negedge clk);
        start = 1'b1; len = 11'(v.n); e_in = v.e; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 48'(busy), 48'd1);
        chk({tag, "_errs_cleared"}, {46'd0, range_err, timeout_err}, 48'd0);
        for (int k = 0; k < v.n; k++) begin
            if (v.gap > 0) begin
                op_valid = 1'b0;
                for (int g = 0; g < v.gap; g++) begin
                    if (v.poke && g == 0) begin
                        start = 1'b1; len = 11'd3; e_in = 16'hDEAD;
                    end
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            op_valid = 1'b1; op_a = v.a[k]; op_s = v.s[k];
            w = 0;
            while (!op_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) chk({tag, "_op_ready_timeout"}, 48'd0, 48'd1);
            @(negedge clk);
            op_valid = 1'b0;
        end
        w = 0;
        while (!res_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_res_valid"}, 48'(res_valid), 48'd1);
        if (v.gap == 0) chk({tag, "_latency"}, 48'(cyc - c0), 48'(1 + 4 * v.n));
        chk({tag, "_res_data"}, 48'(res_data), 48'(v.exp));
        chk({tag, "_mac_en_pulses"}, 48'(en_cnt - en0), 48'(v.n));
        chk({tag, "_op_handshakes"}, 48'(hs_cnt - hs0), 48'(v.n));
        res_ready = 1'b1;
        #1;
        chk({tag, "_job_done"}, 48'(job_done), 48'd1);
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_idle_after_accept"}, {46'd0, busy, job_done}, 48'd0);
        chk({tag, "_range_err"}, 48'(range_err), 48'(v.rerr));
    endtask

    initial begin
        int c0, w;
        bit saw_rv;
        vecs[0] = '{1, 16'd5,    '{16'd3, 0, 0, 0},      '{8'd2, 0, 0, 0},       16'h000B, 0, 0, 0};
        vecs[1] = '{1, 16'd0,    '{16'h0100, 0, 0, 0},   '{8'hF0, 0, 0, 0},      16'hF000, 0, 0, 0};
        vecs[2] = '{1, 16'd7,    '{16'd9, 0, 0, 0},      '{8'h20, 0, 0, 0},      16'h0007, 1, 0, 0};
        vecs[3] = '{1, 16'h0010, '{16'hFFFF, 0, 0, 0},   '{8'd15, 0, 0, 0},      16'h0001, 0, 0, 0};
        vecs[4] = '{4, 16'd100,  '{16'd1, 16'd2, 16'd3, 16'd4}, '{8'd1, 8'hFF, 8'd2, 8'hFD}, 16'h005D, 0, 0, 0};
        vecs[5] = '{0, 16'h1234, '{0, 0, 0, 0},          '{0, 0, 0, 0},          16'h1234, 0, 0, 0};
        vecs[6] = '{2, 16'd0,    '{16'h0010, 16'd2, 0, 0}, '{8'h1F, 8'd3, 0, 0}, 16'hFFF6, 1, 2, 1};
        vecs[7] = '{3, 16'hFFFF, '{16'h8000, 16'h8000, 16'd5, 0}, '{8'd1, 8'd1, 8'hF0, 0}, 16'hFFAF, 0, 1, 1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {40'd0, busy, op_ready, res_valid, job_done, mac_en, range_err, timeout_err, 1'b0}, 48'd0);
        chk("reset_data", {res_data, mac_a, mac_b, 8'h0}, 48'd0);
        chk("reset_mac_c", 48'(mac_c), 48'd0);
        rstn = 1'b1;

        foreach (vecs[i]) run_job(vecs[i], $sformatf("vec%0d", i));

        // Result held stable while the consumer stalls
        @(negedge clk);
        start = 1'b1; len = 11'd0; e_in = 16'hBEEF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {31'd0, res_valid, res_data}, {31'd0, 1'b1, 16'hBEEF});
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("stall_job_done", 48'(job_done), 48'd1);
        @(negedge clk);
        res_ready = 1'b0;

        // MAC never answers: abort after 7 WAIT cycles
        mac_alive = 1'b0;
        saw_rv = 1'b0;
        @(negedge clk);
        start = 1'b1; len = 11'd1; e_in = 16'd1; c0 = cyc;
        @(negedge clk);
        start = 1'b0; op_valid = 1'b1; op_a = 16'd1; op_s = 8'd1;
        @(negedge clk);
        op_valid = 1'b0;
        w = 0;
        while (busy && w < 50) begin
            saw_rv |= res_valid;
            if (cyc - c0 == 9) chk("timeout_busy_last_wait", 48'(busy), 48'd1);
            @(negedge clk);
            w++;
        end
        chk("timeout_abort_cycle", 48'(cyc - c0), 48'd10);
        chk("timeout_err_set", 48'(timeout_err), 48'd1);
        chk("timeout_no_result", 48'(saw_rv), 48'd0);
        mac_alive = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a job
        start = 1'b1; len = 11'd2; e_in = 16'h5555;
        @(negedge clk);
        start = 1'b0; op_valid = 1'b1; op_a = 16'd7; op_s = 8'd3;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        chk("midjob_in_wait", 48'(busy), 48'd1);
        rstn = 1'b0;
        #1;
        chk("midjob_abort_ctrl", {43'd0, busy, op_ready, res_valid, mac_en, range_err}, 48'd0);
        chk("midjob_abort_data", {res_data, mac_a, mac_b, 8'h0}, 48'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_job(vecs[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
